// File: rtl/consmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : consmax_seq_ctrl
//  Purpose  : Sequencer in front of the consmax datapath. LOAD streams the
//             exponent LUT into consmax; RUN forwards one row of scores with
//             a fixed shift, then drains, counts and flags the results.
//  Revision : 1.0  initial release
// ============================================================================
module consmax_seq_ctrl #(
    parameter int IDATA_BIT = 8,
    parameter int ODATA_BIT = 8,
    parameter int CDATA_BIT = 8,
    parameter int LUT_DATA  = 16,
    parameter int LUT_ADDR  = 4,
    parameter int ROW_BIT   = 10,
    parameter int DRAIN_TO  = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_load,
    input  logic                  cmd_run,
    input  logic [ROW_BIT-1:0]    cfg_row_len,
    input  logic [CDATA_BIT-1:0]  cfg_shift,
    input  logic [LUT_DATA-1:0]   lut_in_data,
    input  logic                  lut_in_valid,
    output logic                  lut_in_ready,
    input  logic [IDATA_BIT-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [CDATA_BIT-1:0]  csm_shift,
    output logic                  csm_lut_wen,
    output logic [LUT_ADDR:0]     csm_lut_waddr,
    output logic [LUT_DATA-1:0]   csm_lut_wdata,
    output logic [IDATA_BIT-1:0]  csm_idata,
    output logic                  csm_idata_valid,
    input  logic [ODATA_BIT-1:0]  csm_odata,
    input  logic                  csm_odata_valid,
    output logic [ODATA_BIT-1:0]  out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_stray
);

    // LUT index spans both halves of the consmax table, so it is one bit wider
    // than LUT_ADDR and wraps to zero after the final word.
    localparam int                   LUT_CNT_W = LUT_ADDR + 1;
    localparam logic [LUT_CNT_W-1:0] LUT_LAST  = {LUT_CNT_W{1'b1}};
    localparam int                   IDLE_W    = $clog2(DRAIN_TO + 1);
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(DRAIN_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [LUT_CNT_W-1:0]  lut_cnt;
    logic [ROW_BIT-1:0]    row_len;
    logic [ROW_BIT-1:0]    in_cnt;
    logic [ROW_BIT-1:0]    out_cnt;
    logic [IDLE_W-1:0]     idle_cnt;

    logic lut_acc;
    logic in_acc;
    logic start_load;
    logic start_run;
    logic load_fin;
    logic in_last;
    logic row_fin;
    logic drain_to_hit;
    logic out_room;

    assign lut_in_ready = (state == S_LOAD);
    assign in_ready     = (state == S_RUN) && (in_cnt < row_len);
    assign busy         = (state != S_IDLE);

    assign lut_acc      = lut_in_ready && lut_in_valid;
    assign in_acc       = in_ready && in_valid;
    // Load has priority when both commands arrive together.
    assign start_load   = (state == S_IDLE) && cmd_load;
    assign start_run    = (state == S_IDLE) && !cmd_load && cmd_run && (cfg_row_len != '0);
    assign load_fin     = lut_acc && (lut_cnt == LUT_LAST);
    assign in_last      = in_acc && (in_cnt == row_len - ROW_BIT'(1));
    assign row_fin      = (state == S_DRAIN) && (out_cnt == row_len);
    assign drain_to_hit = (state == S_DRAIN) && !row_fin && !csm_odata_valid &&
                          (idle_cnt == IDLE_LAST);
    assign out_room     = ((state == S_RUN) || (state == S_DRAIN)) && (out_cnt < row_len);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_load) begin
                    state_nxt = S_LOAD;
                end else if (start_run) begin
                    state_nxt = S_RUN;
                end
            end
            S_LOAD: begin
                if (load_fin) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (in_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (row_fin || drain_to_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: LUT write port, score forwarding, result capture, counters, flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lut_cnt         <= '0;
            row_len         <= '0;
            in_cnt          <= '0;
            out_cnt         <= '0;
            idle_cnt        <= '0;
            csm_shift       <= '0;
            csm_lut_wen     <= 1'b0;
            csm_lut_waddr   <= '0;
            csm_lut_wdata   <= '0;
            csm_idata       <= '0;
            csm_idata_valid <= 1'b0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            done            <= 1'b0;
            err_timeout     <= 1'b0;
            err_stray       <= 1'b0;
        end else begin
            csm_lut_wen     <= lut_acc;
            csm_idata_valid <= in_acc;
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            done            <= load_fin || row_fin;

            if (start_load) begin
                lut_cnt <= '0;
            end else if (lut_acc) begin
                csm_lut_waddr <= lut_cnt;
                csm_lut_wdata <= lut_in_data;
                lut_cnt       <= lut_cnt + LUT_CNT_W'(1);
            end

            if (start_run) begin
                row_len   <= cfg_row_len;
                csm_shift <= cfg_shift;
                in_cnt    <= '0;
            end else if (in_acc) begin
                csm_idata <= in_data;
                in_cnt    <= in_cnt + ROW_BIT'(1);
            end

            if (start_load || start_run) begin
                err_timeout <= 1'b0;
                err_stray   <= 1'b0;
            end

            // Results only count while a row is open and not yet complete;
            // anything else from consmax is unexpected.
            if (start_run) begin
                out_cnt <= '0;
            end else if (csm_odata_valid) begin
                if (out_room) begin
                    out_data  <= csm_odata;
                    out_valid <= 1'b1;
                    out_last  <= (out_cnt == row_len - ROW_BIT'(1));
                    out_cnt   <= out_cnt + ROW_BIT'(1);
                end else begin
                    err_stray <= 1'b1;
                end
            end

            // Idle watchdog runs only in DRAIN and restarts on every result.
            if ((state == S_DRAIN) && !csm_odata_valid) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (drain_to_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
